// File: rtl/strlen_pkg.sv
// Shared definitions for the string length sequencer: FSM encoding and word geometry.
package strlen_pkg;

    localparam int unsigned WORD_W         = 64;
    localparam int unsigned BYTES_PER_WORD = 8;
    localparam logic [3:0]  FULL_WORD_LEN  = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_EVAL = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/length_finder.sv
// Combinational byte scan: index of the lowest 0x00 byte in a 64-bit word, 8 when none.
module length_finder
    import strlen_pkg::*;
(
    input  logic [WORD_W-1:0] str,
    output logic [3:0]        len
);

    logic found_s;

    // Lowest-index null byte wins; bytes above it are don't-care
    always_comb begin
        len     = FULL_WORD_LEN;
        found_s = 1'b0;
        for (int i = 0; i < int'(BYTES_PER_WORD); i++) begin
            if (!found_s && (str[i*8 +: 8] == 8'h00)) begin
                len     = 4'(i);
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/string_length_sequencer.sv
// Fetches consecutive memory words and sums their string lengths until a null byte or word limit.
// Optional WAIT watchdog is built when STRLEN_SEQ_TIMEOUT_EN is defined.
module string_length_sequencer
    import strlen_pkg::*;
#(
    parameter int unsigned ADDR_W         = 8,
    parameter int unsigned MAX_WORDS      = 16,
    parameter int unsigned LEN_W          = 8,
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              done,
    output logic [LEN_W-1:0]  total_len,
    output logic              overflow,
    output logic              timeout,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rd_valid,
    input  logic [WORD_W-1:0] mem_rd_data
);

    localparam int unsigned CNT_W = $clog2(MAX_WORDS) + 1;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [LEN_W-1:0]    total_len_q, total_len_d;
    logic                overflow_q, overflow_d;
    logic                timeout_q, timeout_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                mem_rd_en_q, mem_rd_en_d;
    logic [3:0]          word_len;

`ifdef STRLEN_SEQ_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0]     wait_cnt_q, wait_cnt_d;
`endif

    length_finder u_length_finder (
        .str (word_q),
        .len (word_len)
    );

    // Next-state, datapath updates, and next-cycle output decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        cnt_d       = cnt_q;
        word_d      = word_q;
        total_len_d = total_len_q;
        overflow_d  = overflow_q;
        timeout_d   = timeout_q;
`ifdef STRLEN_SEQ_TIMEOUT_EN
        wait_cnt_d  = wait_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    addr_d      = base_addr;
                    cnt_d       = {CNT_W{1'b0}};
                    total_len_d = {LEN_W{1'b0}};
                    overflow_d  = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = ST_REQ;
                end else begin
                    state_d     = ST_IDLE;
                end
            end
            ST_REQ: begin
`ifdef STRLEN_SEQ_TIMEOUT_EN
                wait_cnt_d = {TO_W{1'b0}};
`endif
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (mem_rd_valid) begin
                    word_d  = mem_rd_data;
                    state_d = ST_EVAL;
`ifdef STRLEN_SEQ_TIMEOUT_EN
                end else if (wait_cnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    wait_cnt_d = wait_cnt_q + TO_W'(1);
                    state_d    = ST_WAIT;
                end
`else
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            ST_EVAL: begin
                total_len_d = total_len_q + LEN_W'(word_len);
                if (word_len < FULL_WORD_LEN) begin
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_W'(MAX_WORDS - 1)) begin
                    overflow_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    // Address rolls over naturally at the top of memory
                    addr_d  = addr_q + ADDR_W'(1);
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        mem_rd_en_d = (state_d == ST_REQ);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= {ADDR_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            word_q      <= {WORD_W{1'b0}};
            total_len_q <= {LEN_W{1'b0}};
            overflow_q  <= 1'b0;
            timeout_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mem_rd_en_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            total_len_q <= total_len_d;
            overflow_q  <= overflow_d;
            timeout_q   <= timeout_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mem_rd_en_q <= mem_rd_en_d;
        end
    end

`ifdef STRLEN_SEQ_TIMEOUT_EN
    // WAIT watchdog counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt_q <= {TO_W{1'b0}};
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign total_len = total_len_q;
    assign overflow  = overflow_q;
    assign timeout   = timeout_q;
    assign mem_rd_en = mem_rd_en_q;
    assign mem_addr  = addr_q;

endmodule

// File: tb/tb_string_length_sequencer.sv
// Self-checking bench: directed vector table, reset/abort sequences and randomized scans vs a reference model.
module tb_string_length_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  base_addr;
    logic        busy, done, overflow, timeout, mem_rd_en;
    logic [7:0]  total_len;
    logic [7:0]  mem_addr;
    logic        mem_rd_valid;
    logic [63:0] mem_rd_data;

    int n_chk  = 0;
    int n_fail = 0;

    logic [63:0] mem [256];
    int          lat          = 1;
    int          silent_after = 1000;
    int          nresp        = 0;
    int          pend         = 0;
    logic [7:0]  pend_addr    = 8'h00;
    bit          spur_req     = 1'b0;
    bit          force_valid  = 1'b0;
    logic [7:0]  rd_log [$];

    string_length_sequencer #(
        .ADDR_W(8), .MAX_WORDS(4), .LEN_W(8), .TIMEOUT_CYCLES(64)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy), .done(done), .total_len(total_len), .overflow(overflow),
        .timeout(timeout), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
        .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data)
    );

    always #5 clk = ~clk;

    // Memory responder: latency counted in cycles from the request cycle
    initial begin
        mem_rd_valid = 1'b0;
        mem_rd_data  = 64'h0;
        forever begin
            @(posedge clk);
            #1;
            mem_rd_valid = 1'b0;
            if (force_valid) begin
                mem_rd_valid = 1'b1;
                mem_rd_data  = 64'h0;
                force_valid  = 1'b0;
            end else if (mem_rd_en) begin
                rd_log.push_back(mem_addr);
                pend_addr = mem_addr;
                pend      = lat;
                if (spur_req) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = 64'h0;
                    spur_req     = 1'b0;
                end
            end else if (pend > 0) begin
                pend--;
                if (pend == 0 && nresp < silent_after) begin
                    mem_rd_valid = 1'b1;
                    mem_rd_data  = mem[pend_addr];
                    nresp++;
                end
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: scan bytes one at a time across words
    task automatic ref_scan(input logic [7:0] base, input int maxw,
                            output int len, output bit ovf, output int nwords);
        len = 0; ovf = 1'b0; nwords = 0;
        for (int w = 0; w < maxw; w++) begin
            logic [7:0]  a;
            logic [63:0] word;
            int          idx;
            a = base + 8'(w);
            word = mem[a];
            idx = 8;
            for (int b = 7; b >= 0; b--)
                if (word[b*8 +: 8] == 8'h00) idx = b;
            len += idx;
            nwords++;
            if (idx < 8) break;
            if (w == maxw - 1) ovf = 1'b1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_scan(input logic [7:0] base, input int l, input bit disturb,
                            input int budget, output int cyc);
        rd_log.delete();
        lat = l; nresp = 0; pend = 0;
        start = 1'b1;
        base_addr = base;
        tick();
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < budget) begin
            if (disturb && cyc == 2) begin
                start = 1'b1;
                base_addr = 8'h80;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
    endtask

    task automatic verify(input string nm, input logic [7:0] base, input int l, input bit disturb,
                          input int exp_len, input bit exp_ovf, input int exp_reads, input int exp_cyc);
        int cyc;
        silent_after = 1000;
        spur_req = disturb;
        run_scan(base, l, disturb, 200, cyc);
        check({nm, ".cycles"}, 64'(cyc), 64'(exp_cyc));
        check({nm, ".done"}, 64'(done), 64'd1);
        check({nm, ".total_len"}, 64'(total_len), 64'(exp_len));
        check({nm, ".overflow"}, 64'(overflow), 64'(exp_ovf));
        check({nm, ".timeout"}, 64'(timeout), 64'd0);
        check({nm, ".reads"}, 64'(rd_log.size()), 64'(exp_reads));
        for (int i = 0; i < rd_log.size(); i++) begin
            logic [7:0] ea;
            ea = base + 8'(i);
            check({nm, ".addr"}, 64'(rd_log[i]), 64'(ea));
        end
        tick();
        check({nm, ".done_pulse"}, 64'(done), 64'd0);
        check({nm, ".idle"}, 64'(busy), 64'd0);
        check({nm, ".len_held"}, 64'(total_len), 64'(exp_len));
    endtask

    typedef struct {
        logic [7:0] base;
        int         lat;
        bit         disturb;
        int         exp_len;
        bit         exp_ovf;
        int         exp_reads;
        int         exp_cyc;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int cyc, mlen, mwords;
        bit movf;

        tbl[0] = '{8'h10, 1, 1'b0, 0,  1'b0, 1, 4};
        tbl[1] = '{8'h20, 3, 1'b0, 10, 1'b0, 2, 11};
        tbl[2] = '{8'h40, 2, 1'b0, 32, 1'b1, 4, 17};
        tbl[3] = '{8'hFF, 1, 1'b0, 8,  1'b0, 2, 7};
        tbl[4] = '{8'h20, 3, 1'b1, 10, 1'b0, 2, 11};

        for (int i = 0; i < 256; i++) mem[i] = 64'h0;
        mem[8'h10] = 64'hAABBCCDDEEFFAA00;
        mem[8'h20] = 64'hAABBCCDDEEFFAA99;
        mem[8'h21] = 64'hAABBCC00EE00FFAA;
        for (int i = 0; i < 5; i++) mem[8'h40 + i] = 64'h1111111111111111;
        mem[8'hFF] = 64'h1111111111111111;
        mem[8'h00] = 64'h1111111111111100;
        mem[8'h30] = 64'h1111111111111111;
        mem[8'h31] = 64'h1111111111111111;

        rst_n = 1'b0; start = 1'b0; base_addr = 8'h00;
        repeat (3) tick();
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.total_len", 64'(total_len), 64'd0);
        check("rst.overflow", 64'(overflow), 64'd0);
        check("rst.timeout", 64'(timeout), 64'd0);
        check("rst.mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("rst.mem_addr", 64'(mem_addr), 64'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++)
            verify($sformatf("vec%0d", i), tbl[i].base, tbl[i].lat, tbl[i].disturb,
                   tbl[i].exp_len, tbl[i].exp_ovf, tbl[i].exp_reads, tbl[i].exp_cyc);

        // Reset while waiting on the second word, with a partial sum already accumulated
        silent_after = 1;
        rd_log.delete(); lat = 2; nresp = 0; pend = 0;
        start = 1'b1; base_addr = 8'h30;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("midrst.busy_before", 64'(busy), 64'd1);
        check("midrst.partial_len", 64'(total_len), 64'd8);
        rst_n = 1'b0;
        tick();
        check("midrst.busy", 64'(busy), 64'd0);
        check("midrst.total_len", 64'(total_len), 64'd0);
        check("midrst.mem_rd_en", 64'(mem_rd_en), 64'd0);
        check("midrst.mem_addr", 64'(mem_addr), 64'd0);
        check("midrst.done", 64'(done), 64'd0);
        rst_n = 1'b1;
        force_valid = 1'b1;
        repeat (3) tick();
        check("late_valid.busy", 64'(busy), 64'd0);
        check("late_valid.done", 64'(done), 64'd0);

        // Memory that never answers
        silent_after = 0;
        run_scan(8'h50, 1, 1'b0, 200, cyc);
`ifdef STRLEN_SEQ_TIMEOUT_EN
        check("timeout.cycles", 64'(cyc), 64'd66);
        check("timeout.flag", 64'(timeout), 64'd1);
        check("timeout.total_len", 64'(total_len), 64'd0);
        check("timeout.overflow", 64'(overflow), 64'd0);
        tick();
        check("timeout.idle", 64'(busy), 64'd0);
`else
        check("hang.no_done", 64'(done), 64'd0);
        check("hang.busy", 64'(busy), 64'd1);
        check("hang.timeout", 64'(timeout), 64'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        check("hang.recovered", 64'(busy), 64'd0);
`endif

        // Randomized scans against the reference model
        for (int t = 0; t < 40; t++) begin
            logic [7:0] base;
            int l;
            base = 8'($urandom_range(0, 255));
            l = $urandom_range(1, 4);
            for (int k = 0; k < 4; k++) begin
                logic [63:0] w;
                logic [7:0]  a;
                for (int b = 0; b < 8; b++)
                    w[b*8 +: 8] = ($urandom_range(0, 11) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
                a = base + 8'(k);
                mem[a] = w;
            end
            ref_scan(base, 4, mlen, movf, mwords);
            verify($sformatf("rnd%0d", t), base, l, 1'b0, mlen, movf, mwords, mwords * (l + 2) + 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
